led_fade_ctrl: RTL and testbench
================================

Name: led_fade_ctrl

Overview:
Brightness sequencer for the PWM LED dimmer. It contains its own PWM period counter and drives `led` directly.
- Runs a repeating "breathing" profile: ramp up → hold bright → ramp down → hold dark.
- Changes brightness only at PWM period boundaries, so no period ever carries a partial duty.
- Sits between board-level enable logic and the LED pin; exposes level and state for debug/ILA.

Parameters:
- CNT_W, 8, PWM counter width. PWM period = 2^CNT_W cycles; FULL = 2^CNT_W.
- STEP, 8, level increment/decrement per brightness step (>=1).
- STEP_PERIODS, 4, PWM periods per brightness step (>=1).
- HOLD_PERIODS, 64, PWM periods spent in each hold state (>=1).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- en  input  1  run enable, level-sensitive
- led  output  1  PWM LED drive
- level  output  CNT_W+1  current brightness, 0..FULL
- state  output  3  FSM state: IDLE=0, RAMP_UP=1, HOLD_HI=2, RAMP_DN=3, HOLD_LO=4
- period_tick  output  1  high in the cycle where pwm_cnt == 2^CNT_W-1 and state != IDLE
- cycle_done  output  1  one-cycle pulse on the HOLD_LO→RAMP_UP transition

Behaviour:
- Clock and reset: one clock domain, `clk`. `rst` is asynchronous, active-high.
- While rst=1: state=IDLE; pwm_cnt, div_cnt, hold_cnt and level all 0; led=0, period_tick=0, cycle_done=0.
- PWM counter:
  - pwm_cnt increments every cycle when state != IDLE, wrapping 2^CNT_W-1 → 0.
  - Held at 0 in IDLE.
- LED output (combinational from registers): led = (state != IDLE) && (pwm_cnt < duty).
  - duty = level, except when the optional feature is compiled in.
  - level=0 → led constant 0; level=FULL → led constant 1.
- Step event: period_tick && div_cnt == STEP_PERIODS-1.
  - div_cnt counts period_ticks 0..STEP_PERIODS-1 in the ramp states.
  - div_cnt clears on every state change.
- Hold-done event: period_tick && hold_cnt == HOLD_PERIODS-1.
  - hold_cnt counts period_ticks in the hold states.
  - hold_cnt clears on every state change.
- State transitions (all registered):
  - IDLE, en=1 → RAMP_UP; level=0, pwm_cnt=0.
  - RAMP_UP, step event → level = min(level+STEP, FULL). If the new level == FULL → HOLD_HI.
  - HOLD_HI, hold-done event → RAMP_DN. Level stays FULL during the first ramp-down step.
  - RAMP_DN, step event → level = max(level-STEP, 0). If the new level == 0 → HOLD_LO.
  - HOLD_LO, hold-done event → RAMP_UP, with cycle_done=1 for exactly that cycle.
- en=0 in any non-IDLE state: next cycle state=IDLE; level, pwm_cnt and all counters 0; led=0. No completion of the current period.
- en re-asserted while in IDLE: the profile always restarts from RAMP_UP at level 0.
- Arithmetic: saturating add/sub on a CNT_W+1-bit level, with no wrap. STEP need not divide FULL; the last step saturates.
- level is updated on the same clock edge where pwm_cnt wraps to 0, so every PWM period uses a single duty value.
- Async reset mid-period: immediate return to reset values; no glitch requirement beyond led=0.

Optional Feature:
- Macro: LED_FADE_GAMMA_EN.
- Defined: duty = (level*level) >> CNT_W, using a 2*CNT_W+2-bit product. This gives a perceptually linear fade. Endpoints map 0→0 and FULL→FULL.
- Undefined: duty = level. No multiplier is synthesized.
- Level, FSM and timing are identical in both builds.

Test Plan (CNT_W=4, STEP=4, STEP_PERIODS=1, HOLD_PERIODS=2; period = 16 cycles; gamma off unless stated):
- Reset: rst=1 for 10 ns, en=1 → led=0, level=0, state=0 throughout reset; RAMP_UP on the first edge after release.
- Full profile from en=1: per-period level is 0,4,8,12 | 16,16 | 16,12,8,4 | 0,0. led high-count per period matches the level; cycle_done pulses once at cycle 192, then the pattern repeats.
- Duty shape: in the level=4 period, led=1 exactly for pwm_cnt 0..3; in the HOLD_HI periods, led=1 for all 16 cycles; in HOLD_LO, led=0 for all 16 cycles.
- Abort: drop en in the middle of RAMP_DN (level=8) → next cycle state=0, level=0, led=0. Re-raise en → profile restarts at level 0.
- Saturation: STEP=5 → ramp levels 0,5,10,15,16, then HOLD_HI; ramp down 16,11,6,1,0, then HOLD_LO.
- LED_FADE_GAMMA_EN defined: levels 4, 8, 12, 16 give led high-counts 1, 4, 9, 16 per period.

Source files
------------

// File: rtl/led_fade_ctrl.sv
// Breathing-profile LED sequencer with an internal PWM period counter.
// Optional gamma-corrected duty is compiled in with `define LED_FADE_GAMMA_EN.
module led_fade_ctrl #(
  parameter int CNT_W        = 8,
  parameter int STEP         = 8,
  parameter int STEP_PERIODS = 4,
  parameter int HOLD_PERIODS = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             led,
  output logic [CNT_W:0]   level,
  output logic [2:0]       state,
  output logic             period_tick,
  output logic             cycle_done
);

  localparam int DIV_W  = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam int HOLD_W = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;

  localparam logic [CNT_W:0]   FULL      = {1'b1, {CNT_W{1'b0}}};
  localparam logic [CNT_W:0]   ZERO_LVL  = {(CNT_W+1){1'b0}};
  localparam logic [CNT_W-1:0] PWM_LAST  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] PWM_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] PWM_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W+1:0] STEP_W    = (CNT_W+2)'(STEP);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(STEP_PERIODS - 1);
  localparam logic [DIV_W-1:0] DIV_ZERO  = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_PERIODS - 1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RAMP_UP = 3'd1,
    HOLD_HI = 3'd2,
    RAMP_DN = 3'd3,
    HOLD_LO = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W:0]    level_q, level_d;
  logic              led_q, led_d;
  logic              period_tick_q, period_tick_d;
  logic              cycle_done_q, cycle_done_d;
  logic              tick_s, step_s, hold_done_s;
  logic [CNT_W:0]    lvl_up_s, lvl_dn_s;

  function automatic logic [CNT_W:0] sat_add(input logic [CNT_W:0] lvl);
    logic [CNT_W+1:0] sum;
    sum = {1'b0, lvl} + STEP_W;
    if (sum >= {1'b0, FULL}) begin
      return FULL;
    end else begin
      return sum[CNT_W:0];
    end
  endfunction

  function automatic logic [CNT_W:0] sat_sub(input logic [CNT_W:0] lvl);
    if ({1'b0, lvl} <= STEP_W) begin
      return ZERO_LVL;
    end else begin
      return lvl - STEP_W[CNT_W:0];
    end
  endfunction

  function automatic logic [CNT_W:0] duty_of(input logic [CNT_W:0] lvl);
`ifdef LED_FADE_GAMMA_EN
    logic [2*CNT_W+1:0] prod;
    prod = {{(CNT_W+1){1'b0}}, lvl} * {{(CNT_W+1){1'b0}}, lvl};
    return prod[2*CNT_W:CNT_W];
`else
    return lvl;
`endif
  endfunction

  // Next-state, counters and brightness; outputs precomputed from next values
  always_comb begin
    state_d      = state_q;
    pwm_cnt_d    = pwm_cnt_q;
    div_cnt_d    = div_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    level_d      = level_q;
    cycle_done_d = 1'b0;
    tick_s       = (state_q != IDLE) && (pwm_cnt_q == PWM_LAST);
    step_s       = tick_s && (div_cnt_q == DIV_LAST);
    hold_done_s  = tick_s && (hold_cnt_q == HOLD_LAST);
    lvl_up_s     = sat_add(level_q);
    lvl_dn_s     = sat_sub(level_q);

    if ((state_q == IDLE) || !en) begin
      pwm_cnt_d  = PWM_ZERO;
      div_cnt_d  = DIV_ZERO;
      hold_cnt_d = HOLD_ZERO;
      level_d    = ZERO_LVL;
      if ((state_q == IDLE) && en) begin
        state_d = RAMP_UP;
      end else begin
        state_d = IDLE;
      end
    end else begin
      pwm_cnt_d = pwm_cnt_q + PWM_ONE;
      case (state_q)
        RAMP_UP, RAMP_DN: begin
          if (step_s) begin
            div_cnt_d = DIV_ZERO;
            if (state_q == RAMP_UP) begin
              level_d = lvl_up_s;
              state_d = (lvl_up_s == FULL) ? HOLD_HI : RAMP_UP;
            end else begin
              level_d = lvl_dn_s;
              state_d = (lvl_dn_s == ZERO_LVL) ? HOLD_LO : RAMP_DN;
            end
          end else if (tick_s) begin
            div_cnt_d = div_cnt_q + DIV_ONE;
          end else begin
            div_cnt_d = div_cnt_q;
          end
        end
        HOLD_HI, HOLD_LO: begin
          if (hold_done_s) begin
            hold_cnt_d = HOLD_ZERO;
            if (state_q == HOLD_HI) begin
              state_d = RAMP_DN;
            end else begin
              state_d      = RAMP_UP;
              cycle_done_d = 1'b1;
            end
          end else if (tick_s) begin
            hold_cnt_d = hold_cnt_q + HOLD_ONE;
          end else begin
            hold_cnt_d = hold_cnt_q;
          end
        end
        default: begin
          state_d    = IDLE;
          pwm_cnt_d  = PWM_ZERO;
          div_cnt_d  = DIV_ZERO;
          hold_cnt_d = HOLD_ZERO;
          level_d    = ZERO_LVL;
        end
      endcase
    end

    // led and period_tick are registered copies of their definitions on the next state
    led_d         = (state_d != IDLE) && ({1'b0, pwm_cnt_d} < duty_of(level_d));
    period_tick_d = (state_d != IDLE) && (pwm_cnt_d == PWM_LAST);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pwm_cnt_q     <= PWM_ZERO;
      div_cnt_q     <= DIV_ZERO;
      hold_cnt_q    <= HOLD_ZERO;
      level_q       <= ZERO_LVL;
      led_q         <= 1'b0;
      period_tick_q <= 1'b0;
      cycle_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pwm_cnt_q     <= pwm_cnt_d;
      div_cnt_q     <= div_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      level_q       <= level_d;
      led_q         <= led_d;
      period_tick_q <= period_tick_d;
      cycle_done_q  <= cycle_done_d;
    end
  end

  assign led         = led_q;
  assign level       = level_q;
  assign state       = state_q;
  assign period_tick = period_tick_q;
  assign cycle_done  = cycle_done_q;

endmodule

// File: tb/tb_led_fade_ctrl.sv
// Directed bench for led_fade_ctrl: STEP=4 instance plus a STEP=5 instance for saturation.
module tb_led_fade_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       led_a, led_b;
  logic [4:0] level_a, level_b;
  logic [2:0] state_a, state_b;
  logic       tick_a, tick_b;
  logic       done_a, done_b;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;
  int done_at_a = -1;
  int d0;

  int exp_lvl_a [12] = '{0, 4, 8, 12, 16, 16, 16, 12, 8, 4, 0, 0};
  int exp_lvl_b [12] = '{0, 5, 10, 15, 16, 16, 16, 11, 6, 1, 0, 0};
  int exp_st    [12] = '{1, 1, 1, 1, 2, 2, 3, 3, 3, 3, 4, 4};

  always #5 clk = ~clk;

  led_fade_ctrl #(.CNT_W(4), .STEP(4), .STEP_PERIODS(1), .HOLD_PERIODS(2)) dut_a (
    .clk(clk), .rst(rst), .en(en), .led(led_a), .level(level_a),
    .state(state_a), .period_tick(tick_a), .cycle_done(done_a)
  );

  led_fade_ctrl #(.CNT_W(4), .STEP(5), .STEP_PERIODS(1), .HOLD_PERIODS(2)) dut_b (
    .clk(clk), .rst(rst), .en(en), .led(led_b), .level(level_b),
    .state(state_b), .period_tick(tick_b), .cycle_done(done_b)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_duty(input int l);
`ifdef LED_FADE_GAMMA_EN
    return (l * l) >> 4;
`else
    return l;
`endif
  endfunction

  // Walks n PWM periods from a period boundary, checking each against the profile table
  task automatic run_periods(input int n);
    int q, la_bad, lb_bad, sa_bad, sb_bad, pat_a, pat_b, tk_a, tk_b;
    for (int p = 0; p < n; p++) begin
      q = p % 12;
      la_bad = 0; lb_bad = 0; sa_bad = 0; sb_bad = 0;
      pat_a = 0; pat_b = 0; tk_a = 0; tk_b = 0;
      for (int o = 0; o < 16; o++) begin
        if (level_a !== 5'(exp_lvl_a[q])) la_bad++;
        if (level_b !== 5'(exp_lvl_b[q])) lb_bad++;
        if (state_a !== 3'(exp_st[q])) sa_bad++;
        if (state_b !== 3'(exp_st[q])) sb_bad++;
        if (led_a === 1'b1) pat_a |= (1 << o);
        if (led_b === 1'b1) pat_b |= (1 << o);
        if (tick_a === 1'b1) tk_a |= (1 << o);
        if (tick_b === 1'b1) tk_b |= (1 << o);
        if (done_a === 1'b1) begin
          done_cnt_a++;
          if (done_at_a < 0) done_at_a = cyc;
        end
        if (done_b === 1'b1) done_cnt_b++;
        cyc++;
        @(negedge clk);
      end
      check_eq($sformatf("p%0d_level_a_bad", q), la_bad, 0);
      check_eq($sformatf("p%0d_level_b_bad", q), lb_bad, 0);
      check_eq($sformatf("p%0d_state_a_bad", q), sa_bad, 0);
      check_eq($sformatf("p%0d_state_b_bad", q), sb_bad, 0);
      check_eq($sformatf("p%0d_led_a_pattern", q), pat_a, (1 << exp_duty(exp_lvl_a[q])) - 1);
      check_eq($sformatf("p%0d_led_b_pattern", q), pat_b, (1 << exp_duty(exp_lvl_b[q])) - 1);
      check_eq($sformatf("p%0d_tick_a", q), tk_a, 1 << 15);
      check_eq($sformatf("p%0d_tick_b", q), tk_b, 1 << 15);
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    #2;
    check_eq("rst_state", int'(state_a), 0);
    check_eq("rst_level", int'(level_a), 0);
    check_eq("rst_led", int'(led_a), 0);
    check_eq("rst_tick", int'(tick_a), 0);
    check_eq("rst_done", int'(done_a), 0);
    #6;
    check_eq("rst_state_after_edge", int'(state_a), 0);
    check_eq("rst_led_after_edge", int'(led_a), 0);
    check_eq("rst_level_after_edge", int'(level_a), 0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("start_state", int'(state_a), 1);
    check_eq("start_level", int'(level_a), 0);

    // Two full breathing cycles
    run_periods(24);
    check_eq("done_count_a", done_cnt_a, 1);
    check_eq("done_cycle_a", done_at_a, 192);
    check_eq("done_count_b", done_cnt_b, 1);

    // Abort mid ramp-down at level 8
    run_periods(8);
    repeat (5) @(negedge clk);
    check_eq("pre_abort_level_a", int'(level_a), 8);
    check_eq("pre_abort_state_a", int'(state_a), 3);
    check_eq("pre_abort_level_b", int'(level_b), 6);
    check_eq("pre_abort_led_a", int'(led_a), (5 < exp_duty(8)) ? 1 : 0);
    en = 1'b0;
    @(negedge clk);
    check_eq("abort_state_a", int'(state_a), 0);
    check_eq("abort_level_a", int'(level_a), 0);
    check_eq("abort_led_a", int'(led_a), 0);
    check_eq("abort_tick_a", int'(tick_a), 0);
    check_eq("abort_state_b", int'(state_b), 0);
    check_eq("abort_level_b", int'(level_b), 0);
    repeat (3) @(negedge clk);
    check_eq("idle_hold_state_a", int'(state_a), 0);
    check_eq("idle_hold_led_a", int'(led_a), 0);

    // Restart always begins at level 0
    en = 1'b1;
    @(negedge clk);
    check_eq("restart_state_a", int'(state_a), 1);
    check_eq("restart_level_a", int'(level_a), 0);
    d0 = done_cnt_a;
    run_periods(5);
    check_eq("restart_no_done", done_cnt_a, d0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
